// File: rtl/ws_gen_defs.sv
// rtl/ws_gen_defs.sv - shared state encoding and default wait-state constants for ws_gen
// Package only, no ports. Holds the FSM state type, counter widths and the
// default MEM_WS / IO_WS / TIMEOUT values used by the ws_gen top.
package ws_gen_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DONE  = 2'd3
  } ws_state_t;

  localparam int CNT_W       = 4;
  localparam int TMO_W       = 5;

  localparam int DEF_MEM_WS  = 0;
  localparam int DEF_IO_WS   = 1;
  localparam int DEF_TIMEOUT = 31;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, both flops reset to 1
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, forces both flops to 1
//   d    - asynchronous input
//   q    - synchronized output, two clk edges of latency
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ws_gen.sv
// rtl/ws_gen.sv - wait-state generator for memory and I/O bus cycles with timeout abort
// Ports:
//   clk4     - processor clock, all state changes on the rising edge
//   reset    - asynchronous active-high reset
//   nmem     - active-low memory cycle request (level, clk4 domain)
//   nio      - active-low I/O cycle request (level, clk4 domain)
//   nwaitreq - active-low device wait request (asynchronous)
//   nhalt    - active-low halt, freezes the wait counters while low
//   nws      - active-low wait-state request to the processor (registered)
//   nendext  - active-low external end request, one cycle on abort (registered)
//   nbuserr  - active-low sticky bus-error flag (registered)
//   busy     - high whenever the FSM is not idle (registered)
module ws_gen
  import ws_gen_defs::*;
#(
  parameter int MEM_WS  = DEF_MEM_WS,
  parameter int IO_WS   = DEF_IO_WS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk4,
  input  logic reset,
  input  logic nmem,
  input  logic nio,
  input  logic nwaitreq,
  input  logic nhalt,
  output logic nws,
  output logic nendext,
  output logic nbuserr,
  output logic busy
);

  localparam logic [CNT_W-1:0] MEM_LD  = CNT_W'(MEM_WS);
  localparam logic [CNT_W-1:0] IO_LD   = CNT_W'(IO_WS);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

  ws_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic             wreq_s;
  logic             req;
  logic [CNT_W-1:0] ld_val;

  sync2 u_sync (
    .clk (clk4),
    .rst (reset),
    .d   (nwaitreq),
    .q   (wreq_s)
  );

  assign req    = ~nmem | ~nio;
  // Memory request wins when both are asserted on the same edge.
  assign ld_val = (!nmem) ? MEM_LD : IO_LD;

  always_ff @(posedge clk4 or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tmo     <= '0;
      nws     <= 1'b1;
      nendext <= 1'b1;
      nbuserr <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            cnt     <= ld_val;
            tmo     <= '0;
            nbuserr <= 1'b1;
            busy    <= 1'b1;
            // Zero wait states and no device wait: skip WAIT entirely so
            // nws never drops.
            if (ld_val == '0 && wreq_s) begin
              state <= ST_DONE;
              nws   <= 1'b1;
            end else begin
              state <= ST_WAIT;
              nws   <= 1'b0;
            end
          end
        end

        ST_WAIT: begin
          if (nhalt) begin
            if (tmo == TMO_LIM) begin
              state   <= ST_ABORT;
              nws     <= 1'b1;
              nendext <= 1'b0;
              nbuserr <= 1'b0;
            end else if (cnt <= CNT_W'(1) && wreq_s) begin
              // Exit on cnt==1 rather than 0 so nws is low for exactly
              // N cycles: the load edge already counts as the first one.
              state <= ST_DONE;
              nws   <= 1'b1;
            end else begin
              if (cnt != '0) cnt <= cnt - CNT_W'(1);
              if (tmo != '1) tmo <= tmo + TMO_W'(1);
            end
          end
        end

        ST_ABORT: begin
          state   <= ST_DONE;
          nendext <= 1'b1;
        end

        ST_DONE: begin
          // Wait for the request to be withdrawn so a held request does not
          // start a second cycle.
          if (nmem && nio) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws_gen.sv
// tb/tb_ws_gen.sv - directed self-checking bench for ws_gen
// Two instances share the inputs:
//   u_a: MEM_WS=0, IO_WS=2, TIMEOUT=31
//   u_b: MEM_WS=1, IO_WS=3, TIMEOUT=4
module tb_ws_gen;

  logic clk4 = 1'b0;
  logic reset = 1'b1;
  logic nmem = 1'b1;
  logic nio = 1'b1;
  logic nwaitreq = 1'b1;
  logic nhalt = 1'b1;

  logic a_nws, a_nendext, a_nbuserr, a_busy;
  logic b_nws, b_nendext, b_nbuserr, b_busy;

  int total = 0;
  int bad = 0;

  always #5 clk4 = ~clk4;

  ws_gen #(.MEM_WS(0), .IO_WS(2), .TIMEOUT(31)) u_a (
    .clk4     (clk4),
    .reset    (reset),
    .nmem     (nmem),
    .nio      (nio),
    .nwaitreq (nwaitreq),
    .nhalt    (nhalt),
    .nws      (a_nws),
    .nendext  (a_nendext),
    .nbuserr  (a_nbuserr),
    .busy     (a_busy)
  );

  ws_gen #(.MEM_WS(1), .IO_WS(3), .TIMEOUT(4)) u_b (
    .clk4     (clk4),
    .reset    (reset),
    .nmem     (nmem),
    .nio      (nio),
    .nwaitreq (nwaitreq),
    .nhalt    (nhalt),
    .nws      (b_nws),
    .nendext  (b_nendext),
    .nbuserr  (b_nbuserr),
    .busy     (b_busy)
  );

  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk4);
    #1;
  endtask

  // Output vector order: {nws, nendext, nbuserr, busy}
  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({a_nws, a_nendext, a_nbuserr, a_busy} !== 4'b1110) begin
      bad++;
      $display("FAIL reset_a: got %b want 1110", {a_nws, a_nendext, a_nbuserr, a_busy});
    end
    total++;
    if ({b_nws, b_nendext, b_nbuserr, b_busy} !== 4'b1110) begin
      bad++;
      $display("FAIL reset_b: got %b want 1110", {b_nws, b_nendext, b_nbuserr, b_busy});
    end
    reset = 1'b0;
    tick();
    tick();
    total++;
    if ({a_busy, b_busy, a_nws, b_nws} !== 4'b0011) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 0011", {a_busy, b_busy, a_nws, b_nws});
    end
  endtask

  task automatic test_mem_zero();
    logic exp_b;
    nmem = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({a_nws, a_busy} !== 2'b11) begin
        bad++;
        $display("FAIL mem_zero_a[%0d]: got nws,busy=%b want 11", i, {a_nws, a_busy});
      end
      exp_b = (i == 0) ? 1'b0 : 1'b1;
      total++;
      if ({b_nws, b_busy} !== {exp_b, 1'b1}) begin
        bad++;
        $display("FAIL mem_one_b[%0d]: got nws,busy=%b want %b1", i, {b_nws, b_busy}, exp_b);
      end
    end
    nmem = 1'b1;
    tick();
    total++;
    if ({a_busy, b_busy} !== 2'b00) begin
      bad++;
      $display("FAIL mem_release: got busy a,b=%b want 00", {a_busy, b_busy});
    end
  endtask

  task automatic test_io_ws();
    logic exp_a, exp_b;
    nio = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_a = (i < 2) ? 1'b0 : 1'b1;
      exp_b = (i < 3) ? 1'b0 : 1'b1;
      total++;
      if ({a_nws, b_nws, a_busy, b_busy} !== {exp_a, exp_b, 2'b11}) begin
        bad++;
        $display("FAIL io_ws[%0d]: got %b want %b%b11", i, {a_nws, b_nws, a_busy, b_busy}, exp_a, exp_b);
      end
    end
    nio = 1'b1;
    tick();
    total++;
    if ({a_busy, b_busy} !== 2'b00) begin
      bad++;
      $display("FAIL io_release: got busy a,b=%b want 00", {a_busy, b_busy});
    end
  endtask

  task automatic test_device_wait();
    logic exp_a, exp_bws, exp_bend, exp_berr;
    nwaitreq = 1'b0;
    tick();
    tick();
    nmem = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 5) nwaitreq = 1'b1;
      exp_a = (i < 8) ? 1'b0 : 1'b1;
      total++;
      if ({a_nws, a_nendext} !== {exp_a, 1'b1}) begin
        bad++;
        $display("FAIL devwait_a[%0d]: got nws,nendext=%b want %b1", i, {a_nws, a_nendext}, exp_a);
      end
      exp_bws  = (i < 5) ? 1'b0 : 1'b1;
      exp_bend = (i == 5) ? 1'b0 : 1'b1;
      exp_berr = (i < 5) ? 1'b1 : 1'b0;
      total++;
      if ({b_nws, b_nendext, b_nbuserr} !== {exp_bws, exp_bend, exp_berr}) begin
        bad++;
        $display("FAIL abort_b[%0d]: got %b want %b%b%b", i, {b_nws, b_nendext, b_nbuserr}, exp_bws, exp_bend, exp_berr);
      end
    end
    nmem = 1'b1;
    tick();
    total++;
    if ({a_nbuserr, b_nbuserr, a_busy, b_busy} !== 4'b1000) begin
      bad++;
      $display("FAIL sticky_b: got %b want 1000", {a_nbuserr, b_nbuserr, a_busy, b_busy});
    end
  endtask

  task automatic test_timeout();
    logic exp_ws, exp_end, exp_err;
    nwaitreq = 1'b0;
    tick();
    tick();
    nmem = 1'b0;
    for (int i = 0; i < 36; i++) begin
      tick();
      exp_ws  = (i < 32) ? 1'b0 : 1'b1;
      exp_end = (i == 32) ? 1'b0 : 1'b1;
      exp_err = (i < 32) ? 1'b1 : 1'b0;
      total++;
      if ({a_nws, a_nendext, a_nbuserr} !== {exp_ws, exp_end, exp_err}) begin
        bad++;
        $display("FAIL timeout_a[%0d]: got %b want %b%b%b", i, {a_nws, a_nendext, a_nbuserr}, exp_ws, exp_end, exp_err);
      end
    end
    nmem = 1'b1;
    nwaitreq = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if ({a_nbuserr, a_busy, a_nendext} !== 3'b001) begin
      bad++;
      $display("FAIL timeout_sticky: got %b want 001", {a_nbuserr, a_busy, a_nendext});
    end
  endtask

  task automatic test_halt();
    logic exp_a, exp_b;
    nio = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 1) nhalt = 1'b0;
      if (i == 5) nhalt = 1'b1;
      exp_a = (i < 6) ? 1'b0 : 1'b1;
      exp_b = (i < 7) ? 1'b0 : 1'b1;
      total++;
      if ({a_nws, b_nws} !== {exp_a, exp_b}) begin
        bad++;
        $display("FAIL halt[%0d]: got nws a,b=%b want %b%b", i, {a_nws, b_nws}, exp_a, exp_b);
      end
      if (i == 0) begin
        total++;
        if ({a_nbuserr, b_nbuserr} !== 2'b11) begin
          bad++;
          $display("FAIL buserr_clear: got a,b=%b want 11", {a_nbuserr, b_nbuserr});
        end
      end
    end
    nio = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    nio = 1'b0;
    tick();
    tick();
    total++;
    if ({a_nws, b_nws, a_busy, b_busy} !== 4'b0011) begin
      bad++;
      $display("FAIL rmid_pre: got %b want 0011", {a_nws, b_nws, a_busy, b_busy});
    end
    reset = 1'b1;
    #1;
    total++;
    if ({a_nws, a_nendext, a_nbuserr, a_busy, b_nws, b_nendext, b_nbuserr, b_busy} !== 8'b11101110) begin
      bad++;
      $display("FAIL rmid_async: got %b want 11101110", {a_nws, a_nendext, a_nbuserr, a_busy, b_nws, b_nendext, b_nbuserr, b_busy});
    end
    tick();
    total++;
    if ({a_nendext, b_nendext, a_busy, b_busy} !== 4'b1100) begin
      bad++;
      $display("FAIL rmid_hold: got %b want 1100", {a_nendext, b_nendext, a_busy, b_busy});
    end
    reset = 1'b0;
    tick();
    total++;
    if ({a_nws, b_nws, a_busy, b_busy, a_nendext, b_nendext} !== 6'b001111) begin
      bad++;
      $display("FAIL rmid_restart: got %b want 001111", {a_nws, b_nws, a_busy, b_busy, a_nendext, b_nendext});
    end
    tick();
    total++;
    if (a_nws !== 1'b0) begin
      bad++;
      $display("FAIL rmid_ws1: got %b want 0", a_nws);
    end
    tick();
    total++;
    if (a_nws !== 1'b1) begin
      bad++;
      $display("FAIL rmid_ws2: got %b want 1", a_nws);
    end
    nio = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_mem_zero();
    test_io_ws();
    test_device_wait();
    test_timeout();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws_gen.md
WS_GEN -- requirements
Module: ws_gen

Interface
REQ-001 Parameter MEM_WS, default 0, memory-cycle wait states inserted unconditionally (0..15).
REQ-002 Parameter IO_WS, default 1, I/O-cycle wait states inserted unconditionally (0..15).
REQ-003 Parameter TIMEOUT, default 31, maximum WAIT cycles before abort (1..31).
REQ-004 clk4  input  1  processor clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 nmem  input  1  active-low memory bus cycle request, level, synchronous to clk4.
REQ-007 nio  input  1  active-low I/O bus cycle request, level, synchronous to clk4.
REQ-008 nwaitreq  input  1  active-low device wait request, asynchronous to clk4.
REQ-009 nhalt  input  1  active-low halt; freezes all counting while low.
REQ-010 nws  output  1  active-low wait-state request to the µPC (WS#), registered.
REQ-011 nendext  output  1  active-low external end request to the µPC (ENDEXT#), registered.
REQ-012 nbuserr  output  1  active-low sticky bus-error flag, registered.
REQ-013 busy  output  1  high whenever state is not IDLE, registered.

Function
REQ-014 States SHALL be IDLE, WAIT, ABORT, DONE.
REQ-015 nwaitreq SHALL pass through a two-flop synchronizer; wreq_s denotes its output (2-cycle latency).
REQ-016 IDLE: on an edge with nmem or nio low, SHALL load cnt with MEM_WS (nmem low, priority if both low) or IO_WS, clear tmo, set nbuserr high.
REQ-017 From IDLE, if loaded value is 0 and wreq_s high, SHALL go to DONE with nws staying high; otherwise SHALL go to WAIT with nws low from that edge.
REQ-018 WAIT, edge with nhalt high: cnt decrements if nonzero, tmo increments; edge with nhalt low: cnt, tmo, state held, nws stays low.
REQ-019 WAIT SHALL exit to DONE (nws high) on the first non-halted edge where cnt <= 1 and wreq_s high; nws thus low exactly N cycles for N wait states with no device wait.
REQ-020 WAIT SHALL exit to ABORT on a non-halted edge where tmo == TIMEOUT, taking priority over REQ-019.
REQ-021 ABORT SHALL last one cycle: nendext low, nws high, nbuserr low; then DONE.
REQ-022 nbuserr SHALL remain low until the next accepted request (REQ-016) or reset.
REQ-023 DONE SHALL return to IDLE on the first edge with both nmem and nio high; a held request SHALL NOT restart a cycle.
REQ-024 nendext SHALL be low only in ABORT; nws and nendext SHALL never be low simultaneously.
REQ-025 cnt SHALL be 4 bits, tmo 5 bits; neither SHALL wrap.

Reset
REQ-026 reset high SHALL immediately force IDLE, cnt=0, tmo=0, synchronizer flops high, nws=1, nendext=1, nbuserr=1, busy=0.
REQ-027 reset asserted mid-WAIT or mid-ABORT SHALL abandon the cycle with no nendext pulse; after release, a still-low request is accepted as new.

Structure
REQ-028 State encoding and default MEM_WS/IO_WS/TIMEOUT constants SHALL live in a shared include package ws_gen_defs.
REQ-029 The two-flop synchronizer SHALL be a separate sub-module, sync2, with asynchronous active-high reset to 1.

Verification
REQ-030 nmem low, MEM_WS=0, nwaitreq high -> nws never low, busy high from next edge until nmem released.
REQ-031 nio low, IO_WS=2, nwaitreq high -> nws low exactly 2 cycles, then DONE; nio held 5 more cycles -> no second wait.
REQ-032 nmem low, MEM_WS=0, nwaitreq low 6 cycles from request -> nws released 2 cycles after nwaitreq rises.
REQ-033 nwaitreq stuck low, TIMEOUT=31 -> nendext low exactly 1 cycle after 31 counted cycles, nbuserr low until next request.
REQ-034 IO_WS=3, nhalt low 4 cycles during WAIT -> nws low 7 cycles total.
REQ-035 reset pulsed mid-WAIT -> all outputs inactive immediately, no nendext pulse, new cycle accepted after release.
